// File: rtl/usb_rx_packet_ctrl.sv
// Receive-side packet sequencer: checks the PID, forwards data payload to the AES
// input FIFO while holding back the two CRC bytes, and zero-pads to whole AES blocks.
module usb_rx_packet_ctrl #(
  parameter int MAX_PAYLOAD = 64,
  parameter int BLOCK_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_enable,
  input  logic [7:0] rcv_data,
  input  logic       eop,
  input  logic       rcv_error,
  input  logic       fifo_full,
  output logic       fifo_wr,
  output logic [7:0] fifo_wdata,
  output logic       enable_pid,
  output logic       enable_data,
  output logic       enable_nondata,
  output logic       enable_pad,
  output logic [3:0] pid_out,
  output logic [6:0] byte_count,
  output logic       packet_done,
  output logic       packet_error,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_NONDATA = 3'd2,
    S_PAD     = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  localparam int         FW      = $clog2(BLOCK_BYTES);
  localparam logic [6:0] MAX_CNT = 7'(MAX_PAYLOAD);

  state_t        state;
  logic [7:0]    h0;
  logic [7:0]    h1;
  logic [1:0]    occ;
  logic [FW-1:0] fill;

  logic pid_ok;
  logic pid_is_data;
  logic proto_abort;

  assign pid_ok      = (rcv_data[7:4] == ~rcv_data[3:0]);
  assign pid_is_data = (rcv_data[3:0] == 4'b0011) || (rcv_data[3:0] == 4'b1011);
  // A byte and an end-of-packet in the same cycle cannot be ordered, so the packet is dropped.
  assign proto_abort = rcv_error || (w_enable && eop);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      h0             <= 8'h00;
      h1             <= 8'h00;
      occ            <= 2'd0;
      fill           <= '0;
      fifo_wr        <= 1'b0;
      fifo_wdata     <= 8'h00;
      enable_pid     <= 1'b0;
      enable_data    <= 1'b0;
      enable_nondata <= 1'b0;
      enable_pad     <= 1'b0;
      pid_out        <= 4'h0;
      byte_count     <= 7'd0;
      packet_done    <= 1'b0;
      packet_error   <= 1'b0;
    end else begin
      fifo_wr        <= 1'b0;
      enable_pid     <= 1'b0;
      enable_nondata <= 1'b0;
      enable_pad     <= 1'b0;
      packet_done    <= 1'b0;
      packet_error   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (w_enable) begin
            if (!pid_ok) begin
              packet_error <= 1'b1;
              state        <= S_ERR;
            end else begin
              enable_pid <= 1'b1;
              pid_out    <= rcv_data[3:0];
              if (pid_is_data) begin
                state       <= S_DATA;
                enable_data <= 1'b1;
                byte_count  <= 7'd0;
                occ         <= 2'd0;
                h0          <= 8'h00;
                h1          <= 8'h00;
              end else begin
                state <= S_NONDATA;
              end
            end
          end
        end

        S_DATA: begin
          if (proto_abort) begin
            packet_error <= 1'b1;
            enable_data  <= 1'b0;
            state        <= S_ERR;
          end else if (eop) begin
            // Whatever sits in the hold register is the CRC and is simply dropped.
            occ <= 2'd0;
            if (occ != 2'd2) begin
              packet_error <= 1'b1;
              enable_data  <= 1'b0;
              state        <= S_IDLE;
            end else if (byte_count[FW-1:0] == '0) begin
              packet_done <= 1'b1;
              enable_data <= 1'b0;
              state       <= S_IDLE;
            end else begin
              state <= S_PAD;
              if (!fifo_full) begin
                fifo_wr    <= 1'b1;
                fifo_wdata <= 8'h00;
                enable_pad <= 1'b1;
                fill       <= byte_count[FW-1:0] + 1'b1;
              end else begin
                fill <= byte_count[FW-1:0];
              end
            end
          end else if (w_enable) begin
            if (occ == 2'd2) begin
              if (fifo_full || (byte_count == MAX_CNT)) begin
                packet_error <= 1'b1;
                enable_data  <= 1'b0;
                state        <= S_ERR;
              end else begin
                fifo_wr    <= 1'b1;
                fifo_wdata <= h0;
                byte_count <= byte_count + 7'd1;
                h0         <= h1;
                h1         <= rcv_data;
              end
            end else begin
              if (occ == 2'd0) h0 <= rcv_data;
              else             h1 <= rcv_data;
              occ <= occ + 2'd1;
            end
          end
        end

        S_NONDATA: begin
          if (proto_abort) begin
            packet_error <= 1'b1;
            state        <= S_ERR;
          end else if (eop) begin
            enable_nondata <= 1'b1;
            packet_done    <= 1'b1;
            state          <= S_IDLE;
          end
        end

        S_PAD: begin
          // fill tracks (byte_count + pad bytes) modulo the block size.
          if (rcv_error) begin
            packet_error <= 1'b1;
            enable_data  <= 1'b0;
            state        <= S_ERR;
          end else if (fill == '0) begin
            packet_done <= 1'b1;
            enable_data <= 1'b0;
            state       <= S_IDLE;
          end else if (!fifo_full) begin
            fifo_wr    <= 1'b1;
            fifo_wdata <= 8'h00;
            enable_pad <= 1'b1;
            fill       <= fill + 1'b1;
          end
        end

        S_ERR: begin
          if (eop) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl: packet scenarios with hand-computed FIFO
// contents, pulse counts and cycle timing.
module tb_usb_rx_packet_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_enable = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       eop = 1'b0;
  logic       rcv_error = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_wr;
  logic [7:0] fifo_wdata;
  logic       enable_pid;
  logic       enable_data;
  logic       enable_nondata;
  logic       enable_pad;
  logic [3:0] pid_out;
  logic [6:0] byte_count;
  logic       packet_done;
  logic       packet_error;
  logic [2:0] fsm_state;

  usb_rx_packet_ctrl dut (
    .clk(clk), .rst(rst), .w_enable(w_enable), .rcv_data(rcv_data), .eop(eop),
    .rcv_error(rcv_error), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .enable_pid(enable_pid), .enable_data(enable_data),
    .enable_nondata(enable_nondata), .enable_pad(enable_pad), .pid_out(pid_out),
    .byte_count(byte_count), .packet_done(packet_done), .packet_error(packet_error),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];
  int pad_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int nd_cnt = 0;
  int pid_cnt = 0;

  // Monitor samples registered outputs mid-cycle.
  always @(negedge clk) begin
    if (fifo_wr === 1'b1) wr_q.push_back(fifo_wdata);
    if (enable_pad === 1'b1) pad_cnt++;
    if (packet_done === 1'b1) done_cnt++;
    if (packet_error === 1'b1) err_cnt++;
    if (enable_nondata === 1'b1) nd_cnt++;
    if (enable_pid === 1'b1) pid_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    w_enable = 1'b1;
    rcv_data = b;
    tick();
    w_enable = 1'b0;
  endtask

  task automatic send_eop();
    eop = 1'b1;
    tick();
    eop = 1'b0;
  endtask

  task automatic clear_mon();
    exp_q.delete();
    wr_q.delete();
    pad_cnt = 0; done_cnt = 0; err_cnt = 0; nd_cnt = 0; pid_cnt = 0;
  endtask

  function automatic int sb_diff();
    if (wr_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({fifo_wr, enable_pid, enable_data, enable_nondata, enable_pad, packet_done, packet_error} !== 7'b0)
      $display("FAIL reset_strobes: got %b expected 0000000",
               {fifo_wr, enable_pid, enable_data, enable_nondata, enable_pad, packet_done, packet_error});
    else passed++;
    checks++;
    if (pid_out !== 4'h0 || byte_count !== 7'd0 || fifo_wdata !== 8'h00)
      $display("FAIL reset_values: pid %h count %0d wdata %h expected 0 0 00", pid_out, byte_count, fifo_wdata);
    else passed++;
    checks++;
    if (fsm_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_data_aligned();
    int d;
    clear_mon();
    send_byte(8'hC3);
    checks++;
    if (enable_pid !== 1'b1 || pid_out !== 4'h3 || enable_data !== 1'b1)
      $display("FAIL aligned_pid: pid_pulse %b pid %h data %b expected 1 3 1", enable_pid, pid_out, enable_data);
    else passed++;
    send_byte(8'hAA);
    send_byte(8'hAA);
    checks++;
    if (fifo_wr !== 1'b0) $display("FAIL aligned_hold: fifo_wr %b expected 0", fifo_wr);
    else passed++;
    send_byte(8'hAA);
    checks++;
    if (fifo_wr !== 1'b1 || fifo_wdata !== 8'hAA)
      $display("FAIL aligned_first_write: wr %b data %h expected 1 aa", fifo_wr, fifo_wdata);
    else passed++;
    for (int i = 3; i < 16; i++) send_byte(8'hAA);
    send_byte(8'h00);
    send_byte(8'h00);
    send_eop();
    checks++;
    if (packet_done !== 1'b1) $display("FAIL aligned_done: got %b expected 1", packet_done);
    else passed++;
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hAA);
    d = sb_diff();
    checks++;
    if (d != -1) $display("FAIL aligned_writes: diff %0d, %0d writes expected 16", d, wr_q.size());
    else passed++;
    checks++;
    if (byte_count !== 7'd16 || pad_cnt != 0 || done_cnt != 1 || enable_data !== 1'b0)
      $display("FAIL aligned_end: count %0d pads %0d done %0d data %b expected 16 0 1 0",
               byte_count, pad_cnt, done_cnt, enable_data);
    else passed++;
  endtask

  task automatic test_data_pad();
    int d;
    int n;
    clear_mon();
    send_byte(8'h4B);
    checks++;
    if (pid_out !== 4'hB) $display("FAIL pad_pid: got %h expected b", pid_out);
    else passed++;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    send_byte(8'h5C); send_byte(8'h7E);
    send_eop();
    checks++;
    if (fifo_wr !== 1'b1 || enable_pad !== 1'b1 || fifo_wdata !== 8'h00)
      $display("FAIL pad_first: wr %b pad %b data %h expected 1 1 00", fifo_wr, enable_pad, fifo_wdata);
    else passed++;
    n = 0;
    while (packet_done !== 1'b1 && n < 40) begin
      fifo_full = (n == 4 || n == 5);
      tick();
      n++;
      if (n == 5) begin
        checks++;
        if (fifo_wr !== 1'b0) $display("FAIL pad_stall: fifo_wr %b expected 0", fifo_wr);
        else passed++;
      end
    end
    fifo_full = 1'b0;
    checks++;
    if (n != 15) $display("FAIL pad_latency: done after %0d cycles expected 15", n);
    else passed++;
    tick(); tick();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    for (int i = 0; i < 13; i++) exp_q.push_back(8'h00);
    d = sb_diff();
    checks++;
    if (d != -1) $display("FAIL pad_writes: diff %0d, %0d writes expected 16", d, wr_q.size());
    else passed++;
    checks++;
    if (pad_cnt != 13 || byte_count !== 7'd3 || done_cnt != 1 || enable_data !== 1'b0)
      $display("FAIL pad_end: pads %0d count %0d done %0d data %b expected 13 3 1 0",
               pad_cnt, byte_count, done_cnt, enable_data);
    else passed++;
  endtask

  task automatic test_nondata();
    clear_mon();
    send_byte(8'hE1);
    checks++;
    if (enable_pid !== 1'b1 || pid_out !== 4'h1 || enable_data !== 1'b0)
      $display("FAIL nondata_pid: pulse %b pid %h data %b expected 1 1 0", enable_pid, pid_out, enable_data);
    else passed++;
    send_byte(8'h12); send_byte(8'h34);
    send_eop();
    checks++;
    if (enable_nondata !== 1'b1 || packet_done !== 1'b1)
      $display("FAIL nondata_eop: nondata %b done %b expected 1 1", enable_nondata, packet_done);
    else passed++;
    tick();
    checks++;
    if (wr_q.size() != 0 || nd_cnt != 1 || err_cnt != 0)
      $display("FAIL nondata_end: writes %0d nondata %0d errors %0d expected 0 1 0", wr_q.size(), nd_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_bad_pid();
    clear_mon();
    send_byte(8'h00);
    checks++;
    if (packet_error !== 1'b1 || enable_pid !== 1'b0 || pid_out !== 4'h1)
      $display("FAIL badpid: error %b pulse %b pid %h expected 1 0 1", packet_error, enable_pid, pid_out);
    else passed++;
    send_byte(8'h33);
    send_eop();
    send_byte(8'hC3);
    send_byte(8'h11); send_byte(8'h22);
    send_eop();
    checks++;
    if (packet_done !== 1'b1 || byte_count !== 7'd0)
      $display("FAIL empty_done: done %b count %0d expected 1 0", packet_done, byte_count);
    else passed++;
    tick();
    checks++;
    if (wr_q.size() != 0 || err_cnt != 1 || pid_cnt != 1)
      $display("FAIL badpid_end: writes %0d errors %0d pids %0d expected 0 1 1", wr_q.size(), err_cnt, pid_cnt);
    else passed++;
  endtask

  task automatic test_short_crc();
    clear_mon();
    send_byte(8'hC3);
    send_byte(8'h55);
    send_eop();
    checks++;
    if (packet_error !== 1'b1 || packet_done !== 1'b0)
      $display("FAIL short_crc: error %b done %b expected 1 0", packet_error, packet_done);
    else passed++;
    tick();
    checks++;
    if (fsm_state !== ST_IDLE || wr_q.size() != 0)
      $display("FAIL short_crc_end: state %0d writes %0d expected 0 0", fsm_state, wr_q.size());
    else passed++;
  endtask

  task automatic test_max_payload();
    int d;
    clear_mon();
    send_byte(8'h4B);
    for (int i = 0; i < 66; i++) send_byte(8'(i + 8'h40));
    send_eop();
    checks++;
    if (packet_done !== 1'b1 || packet_error !== 1'b0 || byte_count !== 7'd64)
      $display("FAIL max_done: done %b error %b count %0d expected 1 0 64", packet_done, packet_error, byte_count);
    else passed++;
    tick();
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i + 8'h40));
    d = sb_diff();
    checks++;
    if (d != -1 || pad_cnt != 0) $display("FAIL max_writes: diff %0d pads %0d expected -1 0", d, pad_cnt);
    else passed++;
  endtask

  task automatic test_overflow();
    int d;
    clear_mon();
    send_byte(8'hC3);
    for (int i = 0; i < 66; i++) send_byte(8'(i));
    checks++;
    if (packet_error !== 1'b0) $display("FAIL overflow_early: error %b expected 0", packet_error);
    else passed++;
    send_byte(8'd66);
    checks++;
    if (packet_error !== 1'b1 || fifo_wr !== 1'b0 || fsm_state !== ST_ERR)
      $display("FAIL overflow: error %b wr %b state %0d expected 1 0 4", packet_error, fifo_wr, fsm_state);
    else passed++;
    send_eop();
    tick();
    for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
    d = sb_diff();
    checks++;
    if (d != -1 || byte_count !== 7'd64 || fsm_state !== ST_IDLE)
      $display("FAIL overflow_end: diff %0d count %0d state %0d expected -1 64 0", d, byte_count, fsm_state);
    else passed++;
  endtask

  task automatic test_fifo_full_error();
    int d;
    clear_mon();
    send_byte(8'hC3);
    send_byte(8'h10); send_byte(8'h20);
    fifo_full = 1'b1;
    send_byte(8'h30);
    fifo_full = 1'b0;
    checks++;
    if (packet_error !== 1'b1 || fifo_wr !== 1'b0)
      $display("FAIL full_error: error %b wr %b expected 1 0", packet_error, fifo_wr);
    else passed++;
    send_byte(8'h40);
    send_eop();
    tick();
    d = sb_diff();
    checks++;
    if (d != -1 || fsm_state !== ST_IDLE || done_cnt != 0)
      $display("FAIL full_end: diff %0d state %0d done %0d expected -1 0 0", d, fsm_state, done_cnt);
    else passed++;
  endtask

  task automatic test_rcv_error();
    int d;
    clear_mon();
    send_byte(8'hC3);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    rcv_error = 1'b1;
    tick();
    rcv_error = 1'b0;
    checks++;
    if (packet_error !== 1'b1 || fsm_state !== ST_ERR || enable_data !== 1'b0)
      $display("FAIL rcv_error: error %b state %0d data %b expected 1 4 0", packet_error, fsm_state, enable_data);
    else passed++;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
    send_eop();
    tick();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    d = sb_diff();
    checks++;
    if (d != -1 || err_cnt != 1 || done_cnt != 0)
      $display("FAIL rcv_error_end: diff %0d errors %0d done %0d expected -1 1 0", d, err_cnt, done_cnt);
    else passed++;
  endtask

  task automatic test_reset_pad();
    clear_mon();
    send_byte(8'hC3);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    send_eop();
    checks++;
    if (enable_pad !== 1'b1) $display("FAIL rstpad_active: pad %b expected 1", enable_pad);
    else passed++;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({fifo_wr, enable_pid, enable_data, enable_nondata, enable_pad, packet_done, packet_error} !== 7'b0 ||
        pid_out !== 4'h0 || byte_count !== 7'd0 || fsm_state !== ST_IDLE)
      $display("FAIL rstpad: strobes %b pid %h count %0d state %0d expected 0 0 0 0",
               {fifo_wr, enable_pid, enable_data, enable_nondata, enable_pad, packet_done, packet_error},
               pid_out, byte_count, fsm_state);
    else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if (err_cnt != 0 || done_cnt != 0) $display("FAIL rstpad_pulses: errors %0d done %0d expected 0 0", err_cnt, done_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int d;
    int n;
    clear_mon();
    send_byte(8'h2D);
    send_eop();
    send_byte(8'h4B);
    checks++;
    if (enable_pid !== 1'b1 || pid_out !== 4'hB)
      $display("FAIL b2b_pid: pulse %b pid %h expected 1 b", enable_pid, pid_out);
    else passed++;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    send_eop();
    n = 0;
    while (packet_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15) $display("FAIL b2b_latency: done after %0d cycles expected 15", n);
    else passed++;
    tick();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 15; i++) exp_q.push_back(8'h00);
    d = sb_diff();
    checks++;
    if (d != -1 || pad_cnt != 15 || done_cnt != 2 || nd_cnt != 1)
      $display("FAIL b2b_end: diff %0d pads %0d done %0d nondata %0d expected -1 15 2 1", d, pad_cnt, done_cnt, nd_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_data_aligned();
    test_data_pad();
    test_nondata();
    test_bad_pid();
    test_short_crc();
    test_max_payload();
    test_overflow();
    test_fifo_full_error();
    test_rcv_error();
    test_reset_pad();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
